// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port, shared by the cpu bus (r0) and the
// loader/DMA engine (r1). One access in flight; single-cycle strobes; fixed read latency.
//
//   state   | meaning
//   S_IDLE  | sample requests, capture the winner's command
//   S_ISSUE | strobe cycle: mem_rd or mem_wr high for exactly this cycle
//   S_WAIT  | read in flight, counting down to the data-valid cycle
//   S_ACK   | winner's ack pulse, gnt still high, r_rdata valid
module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_adrs,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_ack,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_adrs,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r_rdata,
   output logic [ADDR_W-1:0] mem_adrs,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

   state_t            state_q;
   logic              last_q;
   logic              win_q;
   logic              we_q;
   logic [ADDR_W-1:0] adrs_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        cnt_q;
   logic              gnt0_q, gnt1_q;
   logic              ack0_q, ack1_q;
   logic              rd_q, wr_q;

   logic              win_d;
   logic              we_d;
   logic [ADDR_W-1:0] adrs_d;
   logic [DATA_W-1:0] wdata_d;

   // A tie goes to whoever was not granted last; a lone request simply wins.
   always_comb begin
      win_d = r1_req;
      if (r0_req && r1_req) win_d = ~last_q;
      we_d    = win_d ? r1_we    : r0_we;
      adrs_d  = win_d ? r1_adrs  : r0_adrs;
      wdata_d = win_d ? r1_wdata : r0_wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         adrs_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (r0_req || r1_req) begin
                  win_q   <= win_d;
                  last_q  <= win_d;
                  we_q    <= we_d;
                  adrs_q  <= adrs_d;
                  wdata_q <= wdata_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  wr_q    <= we_d;
                  rd_q    <= ~we_d;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (we_q) begin
                  ack0_q  <= ~win_q;
                  ack1_q  <= win_q;
                  state_q <= S_ACK;
               end else begin
                  cnt_q   <= LAT_M1;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Data is valid in the cycle where the count has reached zero.
               if (cnt_q == 3'd0) begin
                  rdata_q <= mem_rdata;
                  ack0_q  <= ~win_q;
                  ack1_q  <= win_q;
                  state_q <= S_ACK;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_ACK: begin
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign r0_gnt    = gnt0_q;
   assign r1_gnt    = gnt1_q;
   assign r0_ack    = ack0_q;
   assign r1_ack    = ack1_q;
   assign r_rdata   = rdata_q;
   assign mem_adrs  = adrs_q;
   assign mem_wdata = wdata_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=2): expected transactions are queued when
// requests are driven and checked against strobes, grants and acks as the port services them.
module tb_mem_port_arbiter;

   localparam int RD_LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        r0_req = 1'b0, r0_we = 1'b0;
   logic [15:0] r0_adrs = '0, r0_wdata = '0;
   logic        r1_req = 1'b0, r1_we = 1'b0;
   logic [15:0] r1_adrs = '0, r1_wdata = '0;
   logic        r0_gnt, r0_ack, r1_gnt, r1_ack;
   logic [15:0] r_rdata, mem_adrs, mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_adrs(r0_adrs), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_ack(r0_ack),
      .r1_req(r1_req), .r1_we(r1_we), .r1_adrs(r1_adrs), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_ack(r1_ack),
      .r_rdata(r_rdata), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory model: read data appears exactly RD_LAT cycles after the strobe, junk otherwise.
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [15:0] p1_a = '0, p2_a = '0;
   always @(posedge clock) begin
      p1_v <= mem_rd;
      p1_a <= mem_adrs;
      p2_v <= p1_v;
      p2_a <= p1_a;
   end
   assign mem_rdata = p2_v ? (p2_a ^ 16'h1214) : 16'hDEAD;

   typedef struct {
      bit          id;
      bit          we;
      logic [15:0] adrs;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   txn_t q[$];
   bit   b2b_mode = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor / scoreboard
   bit strobe_seen = 1'b0;
   int prev_strobe = 0;
   int b2b_n = 0;
   always @(negedge clock) begin
      if (reset) begin
         strobe_seen = 1'b0;
      end else begin
         chk("gnt_overlap", 64'(r0_gnt & r1_gnt), 64'(0));
         chk("rd_wr_excl", 64'(mem_rd & mem_wr), 64'(0));
         if (!b2b_mode) b2b_n = 0;
         if (r0_gnt || r1_gnt) begin
            if (q.size() == 0) chk("gnt_unexpected", 64'({r1_gnt, r0_gnt}), 64'(0));
            else begin
               chk("gnt_owner", 64'({r1_gnt, r0_gnt}), q[0].id ? 64'(2) : 64'(1));
               chk("mem_adrs_held", 64'(mem_adrs), 64'(q[0].adrs));
            end
         end
         if (mem_rd || mem_wr) begin
            if (q.size() == 0) chk("strobe_unexpected", 64'({mem_rd, mem_wr}), 64'(0));
            else begin
               chk("single_strobe", 64'(strobe_seen), 64'(0));
               chk("strobe_kind", 64'({mem_wr, mem_rd}), q[0].we ? 64'(2) : 64'(1));
               if (q[0].we) chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
               if (b2b_mode && b2b_n > 0) chk("b2b_spacing", 64'(cyc - prev_strobe), 64'(3));
               b2b_n++;
               prev_strobe = cyc;
               strobe_seen = 1'b1;
            end
         end
         if (r0_ack || r1_ack) begin
            if (q.size() == 0) chk("ack_unexpected", 64'({r1_ack, r0_ack}), 64'(0));
            else begin
               chk("ack_owner", 64'({r1_ack, r0_ack}), q[0].id ? 64'(2) : 64'(1));
               chk("ack_after_strobe", 64'(strobe_seen), 64'(1));
               chk("ack_latency", 64'(cyc - prev_strobe),
                   q[0].we ? 64'(1) : 64'(RD_LAT + 1));
               chk("gnt_in_ack", 64'(r0_gnt | r1_gnt), 64'(1));
               if (!q[0].we) chk("r_rdata", 64'(r_rdata), 64'(q[0].rdata));
               void'(q.pop_front());
               strobe_seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input bit id, input bit we, input logic [15:0] a, input logic [15:0] d);
      txn_t t;
      t.id = id; t.we = we; t.adrs = a; t.wdata = d; t.rdata = a ^ 16'h1214;
      q.push_back(t);
      if (!id) begin r0_we = we; r0_adrs = a; r0_wdata = d; r0_req = 1'b1; end
      else     begin r1_we = we; r1_adrs = a; r1_wdata = d; r1_req = 1'b1; end
   endtask

   // which: 0 r0_gnt, 1 r1_gnt, 2 r0_ack, 3 r1_ack; call at a falling edge
   task automatic wait_sig(input int which, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         case (which)
            0: seen = r0_gnt;
            1: seen = r1_gnt;
            2: seen = r0_ack;
            default: seen = r1_ack;
         endcase
         if (!seen) @(negedge clock);
      end
      chk(tag, 64'(seen), 64'(1));
   endtask

   initial begin
      int acks;
      #1;
      chk("reset_outs", 64'({r0_gnt, r0_ack, r1_gnt, r1_ack, mem_rd, mem_wr,
                             mem_adrs, mem_wdata, r_rdata}), 64'(0));
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // 1: r0 write
      issue(0, 1, 16'h0010, 16'hBEEF);
      wait_sig(2, "t1_r0_ack");
      r0_req = 1'b0;
      @(negedge clock);
      chk("t1_rdata_untouched", 64'(r_rdata), 64'(0));

      // 2: r1 read, data 0x1234
      issue(1, 0, 16'h0020, 16'h0000);
      wait_sig(3, "t2_r1_ack");
      chk("t2_rdata", 64'(r_rdata), 64'(16'h1234));
      r1_req = 1'b0;
      @(negedge clock);

      // 3: both held, four writes alternate r0,r1,r0,r1 at one per 3 cycles
      b2b_mode = 1'b1;
      issue(0, 1, 16'h0100, 16'hA000);
      issue(1, 1, 16'h0200, 16'hB000);
      issue(0, 1, 16'h0100, 16'hA000);
      issue(1, 1, 16'h0200, 16'hB000);
      acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         @(negedge clock);
         if (r0_ack || r1_ack) acks++;
      end
      r0_req = 1'b0; r1_req = 1'b0;
      chk("t3_acks", 64'(acks), 64'(4));
      @(negedge clock);
      b2b_mode = 1'b0;
      chk("t3_q_empty", 64'(q.size()), 64'(0));
      chk("t3_rdata_held", 64'(r_rdata), 64'(16'h1234));

      // 4: reset during r1 read wait, then r0 wins the first tie
      issue(1, 0, 16'h0030, 16'h0000);
      wait_sig(1, "t4_r1_gnt");
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("t4_abort_outs", 64'({mem_rd, mem_wr, r0_gnt, r1_gnt, r0_ack, r1_ack}), 64'(0));
      chk("t4_rdata_reset", 64'(r_rdata), 64'(0));
      q.delete();
      r1_req = 1'b0;
      @(negedge clock); @(negedge clock);
      issue(0, 1, 16'h0300, 16'h3333);
      issue(1, 1, 16'h0400, 16'h4444);
      reset = 1'b0;
      wait_sig(2, "t4_r0_ack");
      r0_req = 1'b0;
      wait_sig(3, "t4_r1_ack");
      r1_req = 1'b0;
      @(negedge clock);
      chk("t4_q_empty", 64'(q.size()), 64'(0));

      // 5: r1 pulse while r0 owns the port is withdrawn
      issue(0, 1, 16'h0500, 16'h5555);
      wait_sig(0, "t5_r0_gnt");
      r1_we = 1'b1; r1_adrs = 16'h0555; r1_wdata = 16'h0BAD; r1_req = 1'b1;
      @(negedge clock);
      r1_req = 1'b0;
      wait_sig(2, "t5_r0_ack");
      r0_req = 1'b0;
      repeat (4) @(negedge clock);
      chk("t5_q_empty", 64'(q.size()), 64'(0));

      // 6: r0 read, address changed and request dropped after grant
      issue(0, 0, 16'h0600, 16'h0000);
      wait_sig(0, "t6_r0_gnt");
      r0_adrs = 16'hFFFF;
      r0_req = 1'b0;
      @(negedge clock);
      chk("t6_mem_adrs", 64'(mem_adrs), 64'(16'h0600));
      wait_sig(2, "t6_r0_ack");
      chk("t6_rdata", 64'(r_rdata), 64'(16'h1414));
      @(negedge clock);

      // 7: a write leaves r_rdata alone
      issue(1, 1, 16'h0700, 16'h7777);
      wait_sig(3, "t7_r1_ack");
      r1_req = 1'b0;
      repeat (3) @(negedge clock);
      chk("t7_rdata_held", 64'(r_rdata), 64'(16'h1414));
      chk("t7_q_empty", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
